// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default frame
// width and width helpers.
package uart_pkg;

    localparam int UART_N_BITS = 8;

    localparam int ARB_STATE_W = 2;
    localparam logic [ARB_STATE_W-1:0] ARB_IDLE  = 2'd0;
    localparam logic [ARB_STATE_W-1:0] ARB_START = 2'd1;
    localparam logic [ARB_STATE_W-1:0] ARB_WAIT  = 2'd2;
    localparam logic [ARB_STATE_W-1:0] ARB_GAP   = 2'd3;

    // $clog2 that never yields a zero-width vector
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first valid requester at or above
// rr_ptr, wrapping around.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W:0] sum;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        sum    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            if (!any && req_valid[sum[IDX_W-1:0]]) begin
                any    = 1'b1;
                winner = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte producers with an optional idle gap.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_BITS    = UART_N_BITS,
    parameter int N_REQ     = 4,
    parameter int GAP_TICKS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_tick,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*N_BITS-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_start,
    output logic [N_BITS-1:0]          tx_din,
    input  logic                       tx_done_tick,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int GAP_W = clog2_min1(GAP_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    logic [ARB_STATE_W-1:0] state_q, state_d;
    logic                   tx_start_q, tx_start_d;
    logic [N_REQ-1:0]       req_ready_q, req_ready_d;
    logic [N_BITS-1:0]      tx_din_q, tx_din_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;
    logic                   busy_q, busy_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

    logic                   pick_any;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       rr_ptr;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Pointer advances past the winner while its grant is being issued
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == ARB_START) begin
            rr_ptr_d = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    assign rr_ptr = rr_ptr_q;
`endif

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .any       (pick_any),
        .winner    (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        tx_start_d  = 1'b0;
        req_ready_d = '0;
        tx_din_d    = tx_din_q;
        grant_id_d  = grant_id_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d               = ARB_START;
                    tx_din_d              = req_data[pick_idx*N_BITS +: N_BITS];
                    grant_id_d            = pick_idx;
                    tx_start_d            = 1'b1;
                    req_ready_d[pick_idx] = 1'b1;
                end
            end
            ARB_START: state_d = ARB_WAIT;
            ARB_WAIT: begin
                // A tick coinciding with done is not part of the gap
                if (tx_done_tick) state_d = (GAP_TICKS > 0) ? ARB_GAP : ARB_IDLE;
            end
            ARB_GAP: begin
                if (s_tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        state_d   = ARB_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            tx_din_q    <= '0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_start_q  <= tx_start_d;
            req_ready_q <= req_ready_d;
            tx_din_q    <= tx_din_d;
            grant_id_q  <= grant_id_d;
            busy_q      <= busy_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_din    = tx_din_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: grant table, scoreboard on tx_start,
// gap timing, reset mid-frame, spurious done, zero-gap turnaround.
module tb_uart_tx_arbiter;

    localparam int NB  = 8;
    localparam int NR  = 4;
    localparam int GAP = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_tick = 1'b0;
    logic [NR-1:0]     req_valid, req_valid0;
    logic [NR*NB-1:0]  req_data, req_data0;
    logic [NR-1:0]     req_ready, req_ready0;
    logic              tx_start, tx_start0;
    logic [NB-1:0]     tx_din, tx_din0;
    logic              tx_done_tick, tx_done0;
    logic [1:0]        grant_id, grant_id0;
    logic              busy, busy0;

    uart_tx_arbiter #(.N_BITS(NB), .N_REQ(NR), .GAP_TICKS(GAP)) u_dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .tx_start(tx_start),
        .tx_din(tx_din), .tx_done_tick(tx_done_tick), .grant_id(grant_id), .busy(busy)
    );

    uart_tx_arbiter #(.N_BITS(NB), .N_REQ(NR), .GAP_TICKS(0)) u_dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .req_valid(req_valid0),
        .req_data(req_data0), .req_ready(req_ready0), .tx_start(tx_start0),
        .tx_din(tx_din0), .tx_done_tick(tx_done0), .grant_id(grant_id0), .busy(busy0)
    );

    always #5 clk = ~clk;

    // Baud tick every third cycle, updated just after the edge
    int tdiv = 0;
    always @(posedge clk) begin
        #1;
        tdiv   = (tdiv == 2) ? 0 : tdiv + 1;
        s_tick = (tdiv == 0);
    end

    typedef struct { logic [1:0] id; logic [7:0] data; } exp_t;
    typedef struct { logic [3:0] mask; int cnt; logic [1:0] seq [4]; } vec_t;

    exp_t sbq[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    bit   held_mode = 1'b0;
    bit   counting = 1'b0;
    int   gap_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    function automatic logic [7:0] dbyte(input int r, input int i);
        return 8'((i + 1) * 17 + r * 3);
    endfunction

    function automatic vec_t mk(input logic [3:0] m, input int c,
                                input logic [1:0] s0, s1, s2, s3);
        vec_t v;
        v.mask = m; v.cnt = c;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3;
        return v;
    endfunction

    task automatic push(input logic [1:0] id);
        exp_t e;
        e.id = id;
        e.data = req_data[id*NB +: NB];
        sbq.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready == '0 && n < 400) begin cyc(1); n++; end
        if (req_ready == '0) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin cyc(1); n++; end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Act as uart_tx: accept the grant, finish the frame a few cycles later
    task automatic serve_one(input bit hold, input bit coincide);
        int n = 0;
        wait_ready();
        if (req_ready != '0) begin
            if (!hold) req_valid = req_valid & ~req_ready;
            cyc(3);
            while (coincide && !s_tick && n < 4) begin cyc(1); n++; end
            tx_done_tick = 1'b1;
            cyc(1);
            tx_done_tick = 1'b0;
        end
    endtask

    // Scoreboard and gap monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            counting = 1'b0;
        end else if (tx_start) begin
            if (sbq.size() == 0) begin
                chk("unexpected_start", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("grant_id", 32'(grant_id), 32'(e.id));
                chk("tx_din", 32'(tx_din), 32'(e.data));
                chk("req_ready", 32'(req_ready), 32'(4'b1 << e.id));
            end
            if (counting) begin
                if (held_mode) chk("gap_exact", 32'(gap_cnt), 32'(GAP));
                else           chk("gap_min", 32'(gap_cnt >= GAP), 32'd1);
            end
            counting = 1'b0;
        end else if (tx_done_tick && busy) begin
            counting = 1'b1;
            gap_cnt  = 0;
        end else if (counting && s_tick) begin
            gap_cnt++;
        end
    end

    initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
        vecs[0] = mk(4'b1111, 4, 2'd0, 2'd1, 2'd2, 2'd3);
        vecs[1] = mk(4'b0101, 2, 2'd0, 2'd2, 2'd0, 2'd0);
        vecs[2] = mk(4'b1000, 1, 2'd3, 2'd0, 2'd0, 2'd0);
        vecs[3] = mk(4'b0110, 2, 2'd1, 2'd2, 2'd0, 2'd0);
        vecs[4] = mk(4'b0011, 2, 2'd0, 2'd1, 2'd0, 2'd0);
        vecs[5] = mk(4'b1001, 2, 2'd0, 2'd3, 2'd0, 2'd0);
`else
        vecs[0] = mk(4'b1111, 4, 2'd1, 2'd2, 2'd3, 2'd0);
        vecs[1] = mk(4'b0101, 2, 2'd2, 2'd0, 2'd0, 2'd0);
        vecs[2] = mk(4'b1000, 1, 2'd3, 2'd0, 2'd0, 2'd0);
        vecs[3] = mk(4'b0110, 2, 2'd1, 2'd2, 2'd0, 2'd0);
        vecs[4] = mk(4'b0011, 2, 2'd0, 2'd1, 2'd0, 2'd0);
        vecs[5] = mk(4'b1001, 2, 2'd3, 2'd0, 2'd0, 2'd0);
`endif
        reset = 1'b1; tx_done_tick = 1'b0; tx_done0 = 1'b0;
        req_valid = '0; req_data = '0; req_valid0 = '0; req_data0 = '0;
        cyc(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_din", 32'(tx_din), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        reset = 1'b0;
        cyc(1);

        // Single requester, one-cycle latency
        req_data[7:0] = 8'hA7;
        req_valid = 4'b0001;
        push(2'd0);
        cyc(1);
        chk("latency_start", 32'(tx_start), 32'd1);
        serve_one(1'b0, 1'b0);
        wait_idle();

        // Spurious done in IDLE
        tx_done_tick = 1'b1;
        cyc(1);
        tx_done_tick = 1'b0;
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_ready", 32'(req_ready), 32'd0);
        cyc(1);
        chk("spur_start", 32'(tx_start), 32'd0);
        chk("spur_grant", 32'(grant_id), 32'd0);

        // Grant-order table
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NR; i++) req_data[i*NB +: NB] = dbyte(r + 1, i);
            for (int k = 0; k < vecs[r].cnt; k++) push(vecs[r].seq[k]);
            req_valid = vecs[r].mask;
            for (int k = 0; k < vecs[r].cnt; k++) serve_one(1'b0, 1'b0);
            wait_idle();
        end

        // Reset during WAIT_DONE drops the grant and the pointer
        req_data[23:16] = 8'h6C;
        req_valid = 4'b0100;
        push(2'd2);
        wait_ready();
        cyc(2);
        reset = 1'b1;
        req_valid = '0;
        cyc(1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_start", 32'(tx_start), 32'd0);
        reset = 1'b0;

        // All requesters held; done coincides with s_tick
        held_mode = 1'b1;
        for (int i = 0; i < NR; i++) req_data[i*NB +: NB] = dbyte(0, i);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 5; k++) push(2'd0);
`else
        for (int k = 0; k < 5; k++) push(2'(k % NR));
`endif
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) serve_one(1'b1, 1'b1);
        req_valid = '0;
        wait_idle();
        held_mode = 1'b0;

        // Zero-gap instance: next grant two cycles after done
        req_data0[15:8] = 8'h5A;
        req_valid0 = 4'b0010;
        begin
            int n = 0;
            while (req_ready0 == '0 && n < 50) begin cyc(1); n++; end
        end
        chk("gap0_ready", 32'(req_ready0), 32'h2);
        chk("gap0_grant", 32'(grant_id0), 32'd1);
        chk("gap0_din", 32'(tx_din0), 32'h5A);
        cyc(2);
        tx_done0 = 1'b1;
        cyc(1);
        tx_done0 = 1'b0;
        chk("gap0_idle", 32'(busy0), 32'd0);
        chk("gap0_no_start", 32'(tx_start0), 32'd0);
        cyc(1);
        chk("gap0_turnaround", 32'(tx_start0), 32'd1);
        req_valid0 = '0;

        cyc(2);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
